// File: rtl/instr_decode_stage.sv
// Instruction decode stage: splits each accepted instruction into opcode,
// four register fields and an extended immediate, flags illegal opcodes,
// and holds the decoded records in a 2-entry valid/ready buffer so that
// back-pressure from execute never drops an instruction.
module instr_decode_stage #(
    parameter int                        INSTR_W      = 16,
    parameter int                        OPCODE_W     = 4,
    parameter int                        REG_W        = 2,
    parameter int                        DATA_W       = 16,
    parameter bit                        IMM_SIGNED   = 1'b1,
    parameter logic [(2**OPCODE_W)-1:0]  ILLEGAL_MASK = 16'hF000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    reg_a,
    output logic [REG_W-1:0]    reg_b,
    output logic [REG_W-1:0]    reg_c,
    output logic [REG_W-1:0]    reg_d,
    output logic [DATA_W-1:0]   imm_ext,
    output logic                illegal,
    output logic [15:0]         instr_count
);

    // The immediate is whatever is left below the opcode and register fields.
    localparam int IMM_W = INSTR_W - OPCODE_W - 4 * REG_W;

    if (IMM_W <= 0) begin : g_bad_imm_w
        $error("instr_decode_stage: no room left for the immediate field");
    end
    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("instr_decode_stage: DATA_W is narrower than the immediate");
    end

    // One fully decoded instruction, as stored in a buffer slot.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    reg_a;
        logic [REG_W-1:0]    reg_b;
        logic [REG_W-1:0]    reg_c;
        logic [REG_W-1:0]    reg_d;
        logic [DATA_W-1:0]   imm_ext;
        logic                illegal;
    } dec_t;

    dec_t        r_buf [2];
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [15:0] r_instr_count;

    dec_t        w_dec;
    dec_t        w_head;
    logic [IMM_W-1:0] w_imm;
    logic        w_push;
    logic        w_pop;

    // Handshake qualifiers; in_ready comes from registered occupancy only.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    assign w_imm = instruction[IMM_W-1:0];

    // Decode the incoming instruction so the buffer stores finished records.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
        w_dec         = '0;
        w_dec.opcode  = instruction[INSTR_W-1 -: OPCODE_W];
        w_dec.reg_a   = instruction[INSTR_W-OPCODE_W-1 -: REG_W];
        w_dec.reg_b   = instruction[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
        w_dec.reg_c   = instruction[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
        w_dec.reg_d   = instruction[INSTR_W-OPCODE_W-3*REG_W-1 -: REG_W];
        if (IMM_SIGNED) begin
            w_dec.imm_ext = DATA_W'($signed(w_imm));
        end else begin
            w_dec.imm_ext = DATA_W'(w_imm);
        end
        w_dec.illegal = ILLEGAL_MASK[w_dec.opcode];
    end

    // Buffer slots, pointers, occupancy and accepted-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: both slots are cleared because the outputs must read 0 out of reset.
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_instr_count <= 16'd0;
        end else if (flush) begin
            // A pop in the flush cycle is treated as consumed; a push is dropped.
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            if (w_push) begin
                r_buf[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= ~r_wr_ptr;
                r_instr_count   <= r_instr_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry drives the downstream outputs.
    assign w_head      = r_buf[r_rd_ptr];
    assign opcode      = w_head.opcode;
    assign reg_a       = w_head.reg_a;
    assign reg_b       = w_head.reg_b;
    assign reg_c       = w_head.reg_c;
    assign reg_d       = w_head.reg_d;
    assign imm_ext     = w_head.imm_ext;
    assign illegal     = w_head.illegal;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed vectors with literal expectations
// plus a queue-based model that is compared against both a sign-extending
// and a zero-extending instance on every cycle.
module tb_instr_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] instruction;
    logic        out_ready;

    logic        in_ready,  u_in_ready;
    logic        out_valid, u_out_valid;
    logic [3:0]  opcode,    u_opcode;
    logic [1:0]  reg_a, reg_b, reg_c, reg_d;
    logic [1:0]  u_reg_a, u_reg_b, u_reg_c, u_reg_d;
    logic [15:0] imm_ext,   u_imm_ext;
    logic        illegal,   u_illegal;
    logic [15:0] instr_count, u_instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: raw instructions waiting in the stage, and accept count.
    logic [15:0] m_q[$];
    logic [15:0] m_cnt;
    // Opcodes observed leaving the DUT, in order.
    int          popped[$];

    instr_decode_stage #(.IMM_SIGNED(1'b1)) dut (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
        .imm_ext(imm_ext), .illegal(illegal), .instr_count(instr_count)
    );

    instr_decode_stage #(.IMM_SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(u_in_ready), .instruction(instruction),
        .out_valid(u_out_valid), .out_ready(out_ready),
        .opcode(u_opcode), .reg_a(u_reg_a), .reg_b(u_reg_b), .reg_c(u_reg_c), .reg_d(u_reg_d),
        .imm_ext(u_imm_ext), .illegal(u_illegal), .instr_count(u_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
    endtask

    // Field extraction from the instruction format: [15:12] op, then four 2-bit regs, [3:0] imm.
    function automatic logic [15:0] f_imm(input logic [15:0] ins, input bit sgn);
        int v;
        v = int'(ins) % 16;
        if (sgn && v >= 8) v = v - 16;
        return 16'(v);
    endfunction

    // Model update: same edge semantics as the stage's handshake rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 16'd0;
        end else begin
            bit p_push, p_pop;
            p_push = in_valid && (m_q.size() < 2) && !flush;
            p_pop  = (m_q.size() > 0) && out_ready;
            if (flush) begin
                m_q.delete();
            end else begin
                if (p_pop)  void'(m_q.pop_front());
                if (p_push) m_q.push_back(instruction);
            end
            if (p_push) m_cnt = m_cnt + 16'd1;
        end
    end

    // Compare process: check both instances against the model every cycle.
    always @(negedge clk) begin
        check("in_ready",      32'(in_ready),      32'(m_q.size() < 2));
        check("out_valid",     32'(out_valid),     32'(m_q.size() > 0));
        check("instr_count",   32'(instr_count),   32'(m_cnt));
        check("u_in_ready",    32'(u_in_ready),    32'(m_q.size() < 2));
        check("u_out_valid",   32'(u_out_valid),   32'(m_q.size() > 0));
        check("u_instr_count", 32'(u_instr_count), 32'(m_cnt));
        if (m_q.size() > 0) begin
            logic [15:0] h;
            h = m_q[0];
            check("opcode",    32'(opcode),    32'(h / 4096));
            check("reg_a",     32'(reg_a),     32'((h / 1024) % 4));
            check("reg_b",     32'(reg_b),     32'((h / 256) % 4));
            check("reg_c",     32'(reg_c),     32'((h / 64) % 4));
            check("reg_d",     32'(reg_d),     32'((h / 16) % 4));
            check("imm_ext",   32'(imm_ext),   32'(f_imm(h, 1'b1)));
            check("illegal",   32'(illegal),   32'((h / 4096) >= 12));
            check("u_opcode",  32'(u_opcode),  32'(h / 4096));
            check("u_regs",    32'({u_reg_a, u_reg_b, u_reg_c, u_reg_d}), 32'((h / 16) % 256));
            check("u_imm_ext", 32'(u_imm_ext), 32'(f_imm(h, 1'b0)));
            check("u_illegal", 32'(u_illegal), 32'((h / 4096) >= 12));
        end
        if (out_valid && out_ready && rst_n) popped.push_back(int'(opcode));
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        bit acc;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instruction = 16'h0000;
        out_ready   = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_fields",    32'({opcode, reg_a, reg_b, reg_c, reg_d, illegal}), 32'h0);
        check("rst_imm_ext",   32'(imm_ext),   32'h0);
        check("rst_count",     32'(instr_count), 32'h0);

        // Single decode, signed and unsigned immediate
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 16'h1B4A;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_opcode",    32'(opcode),    32'h1);
        check("t1_regs",      32'({reg_a, reg_b, reg_c, reg_d}), 32'({2'd2, 2'd3, 2'd1, 2'd0}));
        check("t1_imm_s",     32'(imm_ext),   32'hFFFA);
        check("t1_imm_u",     32'(u_imm_ext), 32'h000A);
        check("t1_illegal",   32'(illegal),   32'h0);
        check("t1_count",     32'(instr_count), 32'h1);
        step();
        check("t1_drained",   32'(out_valid), 32'h0);

        // Illegal opcode still delivered
        in_valid    = 1'b1;
        instruction = 16'hC000;
        step();
        in_valid = 1'b0;
        check("t2_out_valid", 32'(out_valid), 32'h1);
        check("t2_opcode",    32'(opcode),    32'hC);
        check("t2_illegal",   32'(illegal),   32'h1);
        check("t2_imm_s",     32'(imm_ext),   32'h0);
        step();
        check("t2_count",     32'(instr_count), 32'h2);

        // Back-pressure: third instruction held by fetch until a slot frees
        do_reset();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 16'h1000;
        step();
        instruction = 16'h2000;
        step();
        check("bp_full", 32'(in_ready), 32'h0);
        instruction = 16'h3000;
        step();
        step();
        check("bp_held_ready", 32'(in_ready),    32'h0);
        check("bp_held_count", 32'(instr_count), 32'h2);
        check("bp_head",       32'(opcode),      32'h1);
        popped.delete();
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            acc = in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                got = 1'b1;
            end
        end
        check("bp_accept_3000", 32'(got), 32'h1);
        for (int k = 0; k < 10 && popped.size() < 3; k++) step();
        check("bp_pop_n", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("bp_order0", 32'(popped[0]), 32'd1);
            check("bp_order1", 32'(popped[1]), 32'd2);
            check("bp_order2", 32'(popped[2]), 32'd3);
        end
        check("bp_count", 32'(instr_count), 32'd3);

        // Streaming: one in, one out per cycle, pointers wrap repeatedly
        step();
        popped.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid    = 1'b1;
            instruction = 16'((i << 12) | i);
            step();
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_head",  32'(opcode),    32'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_pop_n", 32'(popped.size()), 32'd10);
        for (int i = 0; i < popped.size(); i++) check("stream_order", 32'(popped[i]), 32'(i));
        check("stream_count", 32'(instr_count), 32'd13);

        // Flush with both slots full and a concurrent push
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 16'h4000;
        step();
        instruction = 16'h6000;
        step();
        check("fl_full", 32'(in_ready), 32'h0);
        instruction = 16'h5000;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid),   32'h0);
        check("fl_in_ready",  32'(in_ready),    32'h1);
        check("fl_count",     32'(instr_count), 32'd15);
        step();
        check("fl_no_5000",   32'(out_valid),   32'h0);

        // Asynchronous reset between edges with both slots full
        in_valid    = 1'b1;
        instruction = 16'h7000;
        step();
        instruction = 16'h8000;
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", 32'(out_valid),   32'h1);
        check("ar_pre_count", 32'(instr_count), 32'd17);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid),   32'h0);
        check("ar_count",     32'(instr_count), 32'h0);
        check("ar_opcode",    32'(opcode),      32'h0);
        check("ar_in_ready",  32'(in_ready),    32'h1);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ar_after", 32'(out_valid), 32'h0);

        // Accepted-instruction counter wraps at 16 bits
        do_reset();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 16'h1B4A;
        repeat (65535) step();
        check("wrap_ffff", 32'(instr_count), 32'hFFFF);
        step();
        check("wrap_zero", 32'(instr_count), 32'h0);
        in_valid = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
